// File: rtl/clock_time_setter_if.sv
// Signal bundle between the clock's set-time front end and its environment:
// raw tact switches and current time in, edited time, load strobe, mode and blink mask out.
interface clock_time_setter_if;
  logic [7:0] TSW;
  logic [3:0] CUR_H1;
  logic [3:0] CUR_H0;
  logic [3:0] CUR_M1;
  logic [3:0] CUR_M0;
  logic [3:0] SET_H1;
  logic [3:0] SET_H0;
  logic [3:0] SET_M1;
  logic [3:0] SET_M0;
  logic       LOAD;
  logic [1:0] MODE;
  logic [3:0] BLINK;

  modport master (
    output TSW, CUR_H1, CUR_H0, CUR_M1, CUR_M0,
    input  SET_H1, SET_H0, SET_M1, SET_M0, LOAD, MODE, BLINK
  );

  modport slave (
    input  TSW, CUR_H1, CUR_H0, CUR_M1, CUR_M0,
    output SET_H1, SET_H0, SET_M1, SET_M0, LOAD, MODE, BLINK
  );
endinterface

// File: rtl/clock_time_setter.sv
// Debounces the clock's tact switches and runs the set-time state machine that edits
// hours (00..11) and minutes (00..59) in BCD, strobing LOAD when the edit is committed.
module clock_time_setter #(
  parameter int DEB_CYCLES = 50000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000,
  parameter int BLINK_W    = 22
) (
  input  logic               pCLK,
  input  logic               nRST,
  clock_time_setter_if.slave bus
);
  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOUR = 2'b01,
    ST_MIN  = 2'b10
  } state_t;

  state_t             r_state, w_nextState;
  logic [3:0]         r_sync1, r_sync2, r_syncPrev, r_deb, r_debPrev;
  logic [DW-1:0]      r_debCnt [4];
  logic [RW-1:0]      r_rptCnt [2];
  logic [1:0]         r_rptArmed;
  logic [3:0]         r_setH1, r_setH0, r_setM1, r_setM0;
  logic               r_load;
  logic [BLINK_W-1:0] r_blinkCnt;

  logic [3:0] w_press;
  logic [1:0] w_held, w_rptFire;
  logic       w_inSet, w_cancelEv, w_modeEv, w_incRaw, w_decRaw, w_incEv, w_decEv;
  logic [3:0] w_nextH1, w_nextH0, w_nextM1, w_nextM0;
  logic       w_nextLoad, w_blinkClr;
  logic [7:0] w_step;

  function automatic logic [7:0] hourInc(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd1 && u == 4'd1) return 8'h00;
    else if (u == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] hourDec(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd0 && u == 4'd0) return 8'h11;
    else if (u == 4'd0)         return {t - 4'd1, 4'd9};
    else                        return {t, u - 4'd1};
  endfunction

  function automatic logic [7:0] minInc(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd5 && u == 4'd9) return 8'h00;
    else if (u == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] minDec(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd0 && u == 4'd0) return 8'h59;
    else if (u == 4'd0)         return {t - 4'd1, 4'd9};
    else                        return {t, u - 4'd1};
  endfunction

  // Any change of the synchronized level restarts the stability count.
  always_ff @(posedge pCLK) begin
    if (!nRST) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_syncPrev <= '1;
      r_deb      <= '1;
      r_debPrev  <= '1;
      for (int i = 0; i < 4; i++) r_debCnt[i] <= '0;
    end else begin
      r_sync1    <= bus.TSW[3:0];
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
      r_debPrev  <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_syncPrev[i])              r_debCnt[i] <= '0;
        else if (r_debCnt[i] == DW'(DEB_CYCLES - 1))  r_deb[i]    <= r_sync2[i];
        else                                          r_debCnt[i] <= r_debCnt[i] + 1'b1;
      end
    end
  end

  assign w_press = r_debPrev & ~r_deb;
  assign w_inSet = (r_state != ST_RUN);
  // Repeat only while exactly one of INC/DEC is held, so holding both stays frozen.
  assign w_held[0] = ~r_deb[1] & r_deb[2];
  assign w_held[1] = ~r_deb[2] & r_deb[1];

  always_comb begin
    w_rptFire = '0;
    for (int k = 0; k < 2; k++) begin
      w_rptFire[k] = w_inSet && w_held[k] && !w_press[k+1] &&
                     (r_rptArmed[k] ? (r_rptCnt[k] == RW'(RPT_PERIOD - 1))
                                    : (r_rptCnt[k] == RW'(RPT_DELAY - 1)));
    end
  end

  always_ff @(posedge pCLK) begin
    if (!nRST) begin
      r_rptArmed <= '0;
      for (int k = 0; k < 2; k++) r_rptCnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!w_inSet || !w_held[k] || w_press[k+1]) begin
          r_rptCnt[k]   <= '0;
          r_rptArmed[k] <= 1'b0;
        end else if (w_rptFire[k]) begin
          r_rptCnt[k]   <= '0;
          r_rptArmed[k] <= 1'b1;
        end else begin
          r_rptCnt[k]   <= r_rptCnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_cancelEv = w_press[3];
  assign w_modeEv   = w_press[0] & ~w_press[3];
  assign w_incRaw   = w_press[1] | w_rptFire[0];
  assign w_decRaw   = w_press[2] | w_rptFire[1];
  assign w_incEv    = w_incRaw & ~w_decRaw & ~w_press[0] & ~w_press[3];
  assign w_decEv    = w_decRaw & ~w_incRaw & ~w_press[0] & ~w_press[3];

  always_comb begin
    w_nextState = r_state;
    w_nextH1    = r_setH1;
    w_nextH0    = r_setH0;
    w_nextM1    = r_setM1;
    w_nextM0    = r_setM0;
    w_nextLoad  = 1'b0;
    w_blinkClr  = 1'b0;
    w_step      = 8'h00;
    case (r_state)
      ST_RUN: begin
        if (w_modeEv) begin
          w_nextState = ST_HOUR;
          w_nextH1    = bus.CUR_H1;
          w_nextH0    = bus.CUR_H0;
          w_nextM1    = bus.CUR_M1;
          w_nextM0    = bus.CUR_M0;
          w_blinkClr  = 1'b1;
        end
      end
      ST_HOUR: begin
        if (w_cancelEv) begin
          w_nextState = ST_RUN;
        end else if (w_modeEv) begin
          w_nextState = ST_MIN;
          w_blinkClr  = 1'b1;
        end else if (w_incEv || w_decEv) begin
          w_step     = w_incEv ? hourInc(r_setH1, r_setH0) : hourDec(r_setH1, r_setH0);
          w_nextH1   = w_step[7:4];
          w_nextH0   = w_step[3:0];
          w_blinkClr = 1'b1;
        end
      end
      ST_MIN: begin
        if (w_cancelEv) begin
          w_nextState = ST_RUN;
        end else if (w_modeEv) begin
          w_nextState = ST_RUN;
          w_nextLoad  = 1'b1;
        end else if (w_incEv || w_decEv) begin
          w_step     = w_incEv ? minInc(r_setM1, r_setM0) : minDec(r_setM1, r_setM0);
          w_nextM1   = w_step[7:4];
          w_nextM0   = w_step[3:0];
          w_blinkClr = 1'b1;
        end
      end
      default: w_nextState = ST_RUN;
    endcase
  end

  always_ff @(posedge pCLK) begin
    if (!nRST) begin
      r_state    <= ST_RUN;
      r_setH1    <= '0;
      r_setH0    <= '0;
      r_setM1    <= '0;
      r_setM0    <= '0;
      r_load     <= 1'b0;
      r_blinkCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_setH1    <= w_nextH1;
      r_setH0    <= w_nextH0;
      r_setM1    <= w_nextM1;
      r_setM0    <= w_nextM0;
      r_load     <= w_nextLoad;
      r_blinkCnt <= w_blinkClr ? '0 : r_blinkCnt + 1'b1;
    end
  end

  assign bus.SET_H1 = r_setH1;
  assign bus.SET_H0 = r_setH0;
  assign bus.SET_M1 = r_setM1;
  assign bus.SET_M0 = r_setM0;
  assign bus.LOAD   = r_load;
  assign bus.MODE   = r_state;
  assign bus.BLINK  = (r_state == ST_HOUR && r_blinkCnt[BLINK_W-1]) ? 4'b1100 :
                      (r_state == ST_MIN  && r_blinkCnt[BLINK_W-1]) ? 4'b0011 : 4'b0000;
endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter: table of switch presses with expected edit state,
// plus hand sequences for bounce, blink, auto-repeat, simultaneous keys and mid-edit reset.
module tb_clock_time_setter;
  logic pCLK = 1'b0;
  logic nRST;

  clock_time_setter_if bus();

  clock_time_setter #(
    .DEB_CYCLES(4),
    .RPT_DELAY (32),
    .RPT_PERIOD(8),
    .BLINK_W   (4)
  ) dut (
    .pCLK(pCLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 pCLK = ~pCLK;

  typedef struct {
    logic [7:0]  keys;
    logic [15:0] cur;
    logic [1:0]  expMode;
    logic [15:0] expSet;
    int          expLoads;
  } vec_t;

  vec_t vecs [25];
  int errors = 0;
  int checks = 0;
  int loadCount = 0;
  int loadBadMode = 0;
  int modeChanges = 0;
  logic [1:0] prevMode = 2'b00;

  // Passive observer of the strobe and mode history.
  always @(negedge pCLK) begin
    if (bus.LOAD === 1'b1) begin
      loadCount++;
      if (bus.MODE !== 2'b00) loadBadMode++;
    end
    if (bus.MODE !== prevMode && nRST === 1'b1) modeChanges++;
    prevMode = bus.MODE;
  end

  function automatic logic [15:0] setVal();
    return {bus.SET_H1, bus.SET_H0, bus.SET_M1, bus.SET_M0};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge pCLK);
  endtask

  task automatic setCur(input logic [15:0] c);
    bus.CUR_H1 = c[15:12];
    bus.CUR_H0 = c[11:8];
    bus.CUR_M1 = c[7:4];
    bus.CUR_M0 = c[3:0];
  endtask

  task automatic applyStimulus(input logic [7:0] keys);
    @(negedge pCLK);
    bus.TSW = ~keys;
    waitCycles(12);
    bus.TSW = 8'hFF;
    waitCycles(12);
  endtask

  task automatic checkBlinkWindow(input string name, input logic [3:0] pattern, input int expOn);
    int on = 0;
    int off = 0;
    int other = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pCLK);
      if (bus.BLINK === pattern && pattern != 4'b0000) on++;
      else if (bus.BLINK === 4'b0000) off++;
      else other++;
    end
    checkOutput({name, "_on"},    16'(on),    16'(expOn));
    checkOutput({name, "_off"},   16'(off),   16'(16 - expOn));
    checkOutput({name, "_other"}, 16'(other), 16'h0);
  endtask

  initial begin
    int snap;
    int found;
    bus.TSW = 8'hFF;
    setCur(16'h0000);
    nRST = 1'b0;

    vecs[0]  = '{8'hF0, 16'h1058, 2'b00, 16'h0000, 0};
    vecs[1]  = '{8'h02, 16'h1058, 2'b00, 16'h0000, 0};
    vecs[2]  = '{8'h01, 16'h1058, 2'b01, 16'h1058, 0};
    vecs[3]  = '{8'h02, 16'h1058, 2'b01, 16'h1158, 0};
    vecs[4]  = '{8'h02, 16'h1058, 2'b01, 16'h0058, 0};
    vecs[5]  = '{8'h01, 16'h1058, 2'b10, 16'h0058, 0};
    vecs[6]  = '{8'h02, 16'h1058, 2'b10, 16'h0059, 0};
    vecs[7]  = '{8'h02, 16'h1058, 2'b10, 16'h0000, 0};
    vecs[8]  = '{8'h01, 16'h1058, 2'b00, 16'h0000, 1};
    vecs[9]  = '{8'h01, 16'h0000, 2'b01, 16'h0000, 1};
    vecs[10] = '{8'h04, 16'h0000, 2'b01, 16'h1100, 1};
    vecs[11] = '{8'h04, 16'h0000, 2'b01, 16'h1000, 1};
    vecs[12] = '{8'h04, 16'h0000, 2'b01, 16'h0900, 1};
    vecs[13] = '{8'h02, 16'h0000, 2'b01, 16'h1000, 1};
    vecs[14] = '{8'h01, 16'h0000, 2'b10, 16'h1000, 1};
    vecs[15] = '{8'h04, 16'h0000, 2'b10, 16'h1059, 1};
    vecs[16] = '{8'h04, 16'h0000, 2'b10, 16'h1058, 1};
    vecs[17] = '{8'h02, 16'h0000, 2'b10, 16'h1059, 1};
    vecs[18] = '{8'h09, 16'h0000, 2'b00, 16'h1059, 1};
    vecs[19] = '{8'h08, 16'h0335, 2'b00, 16'h1059, 1};
    vecs[20] = '{8'h01, 16'h0709, 2'b01, 16'h0709, 1};
    vecs[21] = '{8'h01, 16'h1234, 2'b10, 16'h0709, 1};
    vecs[22] = '{8'h02, 16'h1234, 2'b10, 16'h0710, 1};
    vecs[23] = '{8'h06, 16'h1234, 2'b10, 16'h0710, 1};
    vecs[24] = '{8'h08, 16'h1234, 2'b00, 16'h0710, 1};

    waitCycles(3);
    checkOutput("reset_mode",  16'(bus.MODE),  16'h0);
    checkOutput("reset_load",  16'(bus.LOAD),  16'h0);
    checkOutput("reset_blink", 16'(bus.BLINK), 16'h0);
    checkOutput("reset_set",   setVal(),       16'h0000);
    nRST = 1'b1;
    waitCycles(10);

    for (int i = 0; i < 25; i++) begin
      setCur(vecs[i].cur);
      applyStimulus(vecs[i].keys);
      checkOutput($sformatf("vec%0d_mode", i),  16'(bus.MODE), 16'(vecs[i].expMode));
      checkOutput($sformatf("vec%0d_set", i),   setVal(),      vecs[i].expSet);
      checkOutput($sformatf("vec%0d_loads", i), 16'(loadCount), 16'(vecs[i].expLoads));
    end
    checkOutput("load_only_in_run", 16'(loadBadMode), 16'h0);

    checkBlinkWindow("blink_run", 4'b0000, 0);
    setCur(16'h0000);
    applyStimulus(8'h01);
    checkBlinkWindow("blink_hour", 4'b1100, 8);
    applyStimulus(8'h01);
    checkBlinkWindow("blink_min", 4'b0011, 8);
    applyStimulus(8'h08);

    // Auto-repeat: first step on press, then +32, then every 8 cycles.
    setCur(16'h0005);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    checkOutput("rpt_start", setVal(), 16'h0005);
    @(negedge pCLK);
    bus.TSW[1] = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge pCLK);
      if (setVal() !== 16'h0005) found = 1;
    end
    checkOutput("rpt_press_seen", 16'(found), 16'h1);
    checkOutput("rpt_k0", setVal(), 16'h0006);
    for (int k = 1; k <= 50; k++) begin
      @(negedge pCLK);
      if (k == 31) checkOutput("rpt_k31", setVal(), 16'h0006);
      if (k == 32) checkOutput("rpt_k32", setVal(), 16'h0007);
      if (k == 32) checkOutput("rpt_k32_blink", 16'(bus.BLINK), 16'h0);
      if (k == 39) checkOutput("rpt_k39", setVal(), 16'h0007);
      if (k == 40) checkOutput("rpt_k40", setVal(), 16'h0008);
      if (k == 47) checkOutput("rpt_k47", setVal(), 16'h0008);
      if (k == 48) checkOutput("rpt_k48", setVal(), 16'h0009);
      if (k == 44) bus.TSW[1] = 1'b1;
    end
    waitCycles(30);
    checkOutput("rpt_after_release", setVal(), 16'h0009);

    // INC and DEC held together must never move the value.
    bus.TSW[2:1] = 2'b00;
    waitCycles(30);
    checkOutput("both_hold_mid", setVal(), 16'h0009);
    waitCycles(30);
    checkOutput("both_hold_end", setVal(), 16'h0009);
    bus.TSW[2:1] = 2'b11;
    waitCycles(20);
    checkOutput("both_release", setVal(), 16'h0009);
    checkOutput("both_mode", 16'(bus.MODE), 16'h2);
    applyStimulus(8'h08);

    // Bouncing MODE switch yields a single event.
    setCur(16'h0423);
    snap = modeChanges;
    for (int b = 0; b < 5; b++) begin
      bus.TSW[0] = 1'b0;
      waitCycles(2);
      bus.TSW[0] = 1'b1;
      waitCycles(2);
    end
    bus.TSW[0] = 1'b0;
    waitCycles(12);
    bus.TSW[0] = 1'b1;
    waitCycles(12);
    checkOutput("bounce_events", 16'(modeChanges - snap), 16'h1);
    checkOutput("bounce_mode", 16'(bus.MODE), 16'h1);
    checkOutput("bounce_set", setVal(), 16'h0423);
    applyStimulus(8'h02);
    checkOutput("edit_before_reset", setVal(), 16'h0523);

    // One-cycle reset in SET_HOUR abandons the edit.
    snap = loadCount;
    nRST = 1'b0;
    @(negedge pCLK);
    nRST = 1'b1;
    checkOutput("mreset_mode",  16'(bus.MODE),  16'h0);
    checkOutput("mreset_blink", 16'(bus.BLINK), 16'h0);
    checkOutput("mreset_set",   setVal(),       16'h0000);
    checkOutput("mreset_load",  16'(bus.LOAD),  16'h0);
    waitCycles(10);
    checkOutput("mreset_no_load", 16'(loadCount - snap), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
